// File: rtl/leve2_pkg.sv
// leve2_pkg: opcode constants, immediate-format enum and opcode-to-format helper
package leve2_pkg;

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] AMO       = 7'b0101111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    function automatic imm_sel_e imm_sel(input logic [6:0] op);
        return (op == JALR || op == LOAD || op == OP_IMM || op == OP_IMM_32 || op == SYSTEM) ? IMM_I :
               (op == STORE)                                                                 ? IMM_S :
               (op == BRANCH)                                                                ? IMM_B :
               (op == LUI || op == AUIPC)                                                    ? IMM_U :
               (op == JAL)                                                                   ? IMM_J : IMM_NONE;
    endfunction

endpackage

// File: rtl/leve2_decode_stage_regfile.sv
// leve2_regfile: integer register file, 2 async reads, 1 write, write-through, x0 hardwired
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr1_i/raddr2_i -> rdata1_o/rdata2_o
module leve2_regfile #(
    parameter int XLEN    = 64,
    parameter int NUM_REG = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(NUM_REG)-1:0] waddr_i,
    input  logic [XLEN-1:0]            wdata_i,
    input  logic [$clog2(NUM_REG)-1:0] raddr1_i,
    input  logic [$clog2(NUM_REG)-1:0] raddr2_i,
    output logic [XLEN-1:0]            rdata1_o,
    output logic [XLEN-1:0]            rdata2_o
);

    logic [XLEN-1:0] mem_q [NUM_REG];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != '0) mem_q[waddr_i] <= wdata_i;
    end

    // Same-cycle write is visible to readers so WB needs no separate bypass path
    assign rdata1_o = (raddr1_i == '0) ? '0 : (we_i && raddr1_i == waddr_i) ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : (we_i && raddr2_i == waddr_i) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/leve2_decode_stage.sv
// leve2_decode_stage: decode/operand-read stage with EX/WB forwarding and load-use stall
// Ports: clk_i, rst_i (async, high); fetch side ivalid_i/iready_o/ipc_i/iinstr_i/iflush_i;
//        execute side ovalid_o/oready_i/opc_o/oinstr_o/rs1_o/rs2_o/oimm_o;
//        forwarding ex_*_i, write-back wb_*_i; stall_cnt_o.
// Optional feature: define LEVE2_ID_PERF_CNT_EN to build the load-use stall counter.
module leve2_decode_stage
    import leve2_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUM_REG = 32,
    parameter int REG_AW  = $clog2(NUM_REG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ivalid_i,
    output logic              iready_o,
    input  logic [XLEN-1:0]   ipc_i,
    input  logic [31:0]       iinstr_i,
    input  logic              iflush_i,
    output logic              ovalid_o,
    input  logic              oready_i,
    output logic [XLEN-1:0]   opc_o,
    output logic [31:0]       oinstr_o,
    output logic [XLEN-1:0]   rs1_o,
    output logic [XLEN-1:0]   rs2_o,
    output logic [XLEN-1:0]   oimm_o,
    input  logic              ex_valid_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_idx_i,
    input  logic [XLEN-1:0]   ex_rd_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]   wb_rd_i,
    output logic [31:0]       stall_cnt_o
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1_idx, rs2_idx;
    logic [XLEN-1:0]   rf_rs1, rf_rs2, rs1_d, rs2_d, imm_d;
    logic [31:0]       imm32;
    imm_sel_e          sel;
    logic              uses_rs1, uses_rs2, load_use, hold, load_en, ovalid_d;
    logic              ovalid_q;
    logic [XLEN-1:0]   opc_q, rs1_q, rs2_q, imm_q;
    logic [31:0]       instr_q;

    assign opcode  = iinstr_i[6:0];
    assign rs1_idx = iinstr_i[15 +: REG_AW];
    assign rs2_idx = iinstr_i[20 +: REG_AW];

    leve2_regfile #(.XLEN(XLEN), .NUM_REG(NUM_REG)) u_rf (
        .clk_i    (clk_i),
        .we_i     (wb_we_i),
        .waddr_i  (wb_rd_idx_i),
        .wdata_i  (wb_rd_i),
        .raddr1_i (rs1_idx),
        .raddr2_i (rs2_idx),
        .rdata1_o (rf_rs1),
        .rdata2_o (rf_rs2)
    );

    always_comb begin
        sel      = imm_sel(opcode);
        imm32    = (sel == IMM_I) ? {{20{iinstr_i[31]}}, iinstr_i[31:20]} :
                   (sel == IMM_S) ? {{20{iinstr_i[31]}}, iinstr_i[31:25], iinstr_i[11:7]} :
                   (sel == IMM_B) ? {{19{iinstr_i[31]}}, iinstr_i[31], iinstr_i[7], iinstr_i[30:25], iinstr_i[11:8], 1'b0} :
                   (sel == IMM_U) ? {iinstr_i[31:12], 12'b0} :
                   (sel == IMM_J) ? {{11{iinstr_i[31]}}, iinstr_i[31], iinstr_i[19:12], iinstr_i[20], iinstr_i[30:21], 1'b0} :
                                    32'b0;
        // All formats fit in 32 bits; widen with sign extension to XLEN
        imm_d    = XLEN'($signed(imm32));
        uses_rs1 = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
        uses_rs2 = opcode == STORE || opcode == BRANCH || opcode == OP || opcode == OP_32 || opcode == AMO;
        load_use = ivalid_i && ex_valid_i && ex_is_load_i && ex_rd_idx_i != '0 &&
                   ((uses_rs1 && rs1_idx == ex_rd_idx_i) || (uses_rs2 && rs2_idx == ex_rd_idx_i));
        hold     = ovalid_q && !oready_i;
        // EX beats WB: the EX result is younger than the one being written back
        rs1_d    = (rs1_idx == '0) ? '0 :
                   (ex_valid_i && !ex_is_load_i && rs1_idx == ex_rd_idx_i) ? ex_rd_i : rf_rs1;
        rs2_d    = (rs2_idx == '0) ? '0 :
                   (ex_valid_i && !ex_is_load_i && rs2_idx == ex_rd_idx_i) ? ex_rd_i : rf_rs2;
        load_en  = !iflush_i && !hold && !load_use;
        ovalid_d = iflush_i ? 1'b0 : hold ? ovalid_q : load_use ? 1'b0 : ivalid_i;
    end

    // A flush always "accepts" so fetch can drop the redirected slot immediately
    assign iready_o = iflush_i || (!hold && !load_use);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovalid_q <= 1'b0;
            opc_q    <= '0;
            instr_q  <= NOP_INSTR;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
        end else begin
            ovalid_q <= ovalid_d;
            if (load_en) begin
                opc_q   <= ipc_i;
                instr_q <= iinstr_i;
                rs1_q   <= rs1_d;
                rs2_q   <= rs2_d;
                imm_q   <= imm_d;
            end
        end
    end

    assign ovalid_o = ovalid_q;
    assign opc_o    = opc_q;
    assign oinstr_o = instr_q;
    assign rs1_o    = rs1_q;
    assign rs2_o    = rs2_q;
    assign oimm_o   = imm_q;

`ifdef LEVE2_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else if (load_use && !iflush_i && !hold && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
